// File: rtl/avalon_master_pkg.sv
// Shared definitions for avalon_burst_master: FSM state encoding, default
// widths and the maximum-legal-burst helper.
package avalon_master_pkg;

  localparam int DEFAULT_DATA_BYTES     = 4;
  localparam int DEFAULT_ADDR_W         = 32;
  localparam int DEFAULT_BURSTCOUNT_W   = 6;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  // Avalon burstcount encodes 1..2**(bw-1); larger codes are reserved.
  function automatic int max_burst(input int bw);
    return 1 << (bw - 1);
  endfunction

endpackage

// File: rtl/avm_beat_counter.sv
// Remaining-beat counter shared by the write and read paths: load with the
// burst length, decrement per completed beat, flag the final beat.
module avm_beat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= len_i;
    end else if (dec_i) begin
      count_q <= count_q - W'(1);
    end
  end

  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst initiator: one read or write burst per command, done/err
// completion pulse. Define AVM_READ_TIMEOUT_EN to add a read-data watchdog.
module avalon_burst_master
  import avalon_master_pkg::*;
#(
  parameter int DATA_BYTES     = DEFAULT_DATA_BYTES,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int BURSTCOUNT_W   = DEFAULT_BURSTCOUNT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [BURSTCOUNT_W-1:0] cmd_len,
  input  logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_W-1:0]       address,
  output logic [DATA_BYTES-1:0]   byteenable,
  output logic                    read,
  output logic                    write,
  output logic [8*DATA_BYTES-1:0] writedata,
  output logic [BURSTCOUNT_W-1:0] burstcount,
  input  logic [8*DATA_BYTES-1:0] readdata,
  input  logic                    readdatavalid,
  input  logic                    waitrequest
);

  localparam int                MAX_BURST = max_burst(BURSTCOUNT_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(DATA_BYTES - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       address_q, address_d;
  logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    cnt_load, cnt_dec, cnt_last;
  logic                    len_bad;
  logic                    timeout;

  assign len_bad = (cmd_len == '0) || (int'(cmd_len) > MAX_BURST);

  avm_beat_counter #(.W(BURSTCOUNT_W)) u_beats (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .len_i  (cmd_len),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

`ifdef AVM_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          in_read, rd_activity;

  // The counter holds cycles elapsed since the last read-side activity, so
  // the abort edge lands exactly TIMEOUT_CYCLES after that activity.
  assign in_read     = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign rd_activity = ((state_q == RD_CMD) && !waitrequest) ||
                       ((state_q == RD_DATA) && readdatavalid);
  assign idle_cnt_d  = (in_read && !rd_activity) ? idle_cnt_q + TW'(1) : TW'(1);
  assign timeout     = in_read && !rd_activity && (idle_cnt_d == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    write        = 1'b0;
    read         = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (len_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            address_d    = cmd_addr & ADDR_MASK;
            burstcount_d = cmd_len;
            cnt_load     = 1'b1;
            state_d      = cmd_write ? WR_BURST : RD_CMD;
          end
        end
      end

      WR_BURST: begin
        write    = wr_valid;
        wr_ready = wr_valid && !waitrequest;
        cnt_dec  = wr_ready;
        if (wr_ready && cnt_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      RD_CMD: begin
        read = 1'b1;
        if (timeout) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!waitrequest) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        rd_valid = readdatavalid;
        cnt_dec  = readdatavalid;
        if (readdatavalid && cnt_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      address_q    <= '0;
      burstcount_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign address    = address_q;
  assign burstcount = burstcount_q;
  assign byteenable = {DATA_BYTES{write | read}};
  assign writedata  = wr_data;
  assign rd_data    = readdata;

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed, table-driven bench for avalon_burst_master: one row per clock
// cycle of stimulus and hand-computed expected outputs.
module tb_avalon_burst_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic [31:0] wr_data, rd_data, writedata, readdata, address;
  logic        wr_valid, wr_ready, rd_valid, done, err;
  logic [3:0]  byteenable;
  logic        read, write, readdatavalid, waitrequest;
  logic [5:0]  burstcount;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  avalon_burst_master #(
    .DATA_BYTES(4), .ADDR_W(32), .BURSTCOUNT_W(6), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .burstcount(burstcount),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  // Expected control bits, packed {cmd_ready, write, read, wr_ready, rd_valid, done, err}
  localparam logic [6:0] E_BUSY   = 7'b0000000;
  localparam logic [6:0] E_IDLE   = 7'b1000000;
  localparam logic [6:0] E_WBEAT  = 7'b0101000;
  localparam logic [6:0] E_WSTALL = 7'b0100000;
  localparam logic [6:0] E_RD     = 7'b0010000;
  localparam logic [6:0] E_RV     = 7'b0000100;
  localparam logic [6:0] E_DONE   = 7'b1000010;
  localparam logic [6:0] E_REJ    = 7'b1000011;

  typedef struct {
    string       name;
    logic        cv, cw;
    logic [31:0] ca;
    logic [5:0]  cl;
    logic        wv;
    logic [31:0] wd;
    logic        wq, rdv;
    logic [31:0] rdd;
    logic [6:0]  ctl;
    logic [31:0] addr;
    logic [5:0]  bc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic cv, logic cw, logic [31:0] ca, logic [5:0] cl,
                              logic wv, logic [31:0] wd, logic wq, logic rdv, logic [31:0] rdd,
                              logic [6:0] ctl, logic [31:0] addr, logic [5:0] bc);
    vec_t r;
    r.name = n; r.cv = cv; r.cw = cw; r.ca = ca; r.cl = cl; r.wv = wv; r.wd = wd;
    r.wq = wq; r.rdv = rdv; r.rdd = rdd; r.ctl = ctl; r.addr = addr; r.bc = bc;
    return r;
  endfunction

  function automatic logic [112:0] actual();
    return {cmd_ready, write, read, wr_ready, rd_valid, done, err,
            byteenable, burstcount, address, writedata, rd_data};
  endfunction

  function automatic logic [112:0] expected(vec_t r);
    logic [3:0] be;
    be = (r.ctl[5] | r.ctl[4]) ? 4'hF : 4'h0;
    return {r.ctl, be, r.bc, r.addr, r.wd, r.rdd};
  endfunction

  task automatic check(input string name, input logic [112:0] act, input logic [112:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t r);
    cmd_valid = r.cv; cmd_write = r.cw; cmd_addr = r.ca; cmd_len = r.cl;
    wr_valid = r.wv; wr_data = r.wd; waitrequest = r.wq;
    readdatavalid = r.rdv; readdata = r.rdd;
    @(negedge clk);
    check(r.name, actual(), expected(r));
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic zero_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; wr_valid = 0;
    wr_data = '0; waitrequest = 0; readdatavalid = 0; readdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [11:0] pat;
    int          k;

    zero_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", actual(), '0);
    reset = 1'b0;

    // Write len=4 at 0x40, no stalls, wr_valid stays high into IDLE.
    tbl.push_back(mk("s1_post_rst", 0,0,32'h0,0,  0,32'h0,0,0,32'h0, E_BUSY, 32'h0, 0));
    tbl.push_back(mk("s1_cmd",      1,1,32'h40,4, 0,32'h0,0,0,32'h0, E_IDLE, 32'h0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("s1_beat", 0,0,32'h0,0, 1,32'hD000 + 32'(i),0,0,32'h0, E_WBEAT, 32'h40, 4));
    tbl.push_back(mk("s1_done",     0,0,32'h0,0,  1,32'hDEAD,0,0,32'h0, E_DONE, 32'h40, 4));
    tbl.push_back(mk("s1_idle",     0,0,32'h0,0,  0,32'h0,0,0,32'h0,    E_IDLE, 32'h40, 4));
    run_tbl();

    // Write len=3 at unaligned 0x83: waitrequest stalls beat 1, wr_valid gaps before beat 2.
    tbl.push_back(mk("s2_cmd",      1,1,32'h83,3,  0,32'h0,0,0,32'h0,   E_IDLE,   32'h40, 4));
    tbl.push_back(mk("s2_wait1",    0,0,32'h0,0,   1,32'hA1,1,0,32'h0,  E_WSTALL, 32'h80, 3));
    tbl.push_back(mk("s2_busy_cmd", 1,0,32'h200,5, 1,32'hA1,1,0,32'h0,  E_WSTALL, 32'h80, 3));
    tbl.push_back(mk("s2_wait3",    0,0,32'h0,0,   1,32'hA1,1,0,32'h0,  E_WSTALL, 32'h80, 3));
    tbl.push_back(mk("s2_beat1",    0,0,32'h0,0,   1,32'hA1,0,0,32'h0,  E_WBEAT,  32'h80, 3));
    tbl.push_back(mk("s2_gap_a",    0,0,32'h0,0,   0,32'hA2,0,0,32'h0,  E_BUSY,   32'h80, 3));
    tbl.push_back(mk("s2_gap_b",    0,0,32'h0,0,   0,32'hA2,1,0,32'h0,  E_BUSY,   32'h80, 3));
    tbl.push_back(mk("s2_beat2",    0,0,32'h0,0,   1,32'hA2,0,0,32'h0,  E_WBEAT,  32'h80, 3));
    tbl.push_back(mk("s2_beat3",    0,0,32'h0,0,   1,32'hA3,0,0,32'h0,  E_WBEAT,  32'h80, 3));
    tbl.push_back(mk("s2_done",     0,0,32'h0,0,   0,32'h0,0,0,32'h0,   E_DONE,   32'h80, 3));
    run_tbl();

    // Read len=8 at 0x100: stray readdatavalid outside RD_DATA, data 0..7 with gaps.
    tbl.push_back(mk("s3_cmd",      1,0,32'h100,8, 0,32'h0,0,1,32'hEE, E_IDLE, 32'h80, 3));
    tbl.push_back(mk("s3_rd_wait",  0,0,32'h0,0,   0,32'h0,1,1,32'hEF, E_RD,   32'h100, 8));
    tbl.push_back(mk("s3_rd_acc",   0,0,32'h0,0,   0,32'h0,0,0,32'h0,  E_RD,   32'h100, 8));
    pat = 12'b110111001101;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (pat[i]) begin
        tbl.push_back(mk("s3_beat", 0,0,32'h0,0, 0,32'h0,0,1,32'(k), E_RV, 32'h100, 8));
        k++;
      end else begin
        tbl.push_back(mk("s3_gap",  0,0,32'h0,0, 0,32'h0,1,0,32'hBAD0, E_BUSY, 32'h100, 8));
      end
    end
    tbl.push_back(mk("s3_done",     0,0,32'h0,0,   0,32'h0,0,1,32'h77, E_DONE, 32'h100, 8));
    run_tbl();

    // Length rejection: 0 and 33 give done+err with no bus activity.
    tbl.push_back(mk("s4_len0",     1,1,32'h500,0,  1,32'h0,0,0,32'h0, E_IDLE, 32'h100, 8));
    tbl.push_back(mk("s4_len33",    1,0,32'h600,33, 0,32'h0,0,0,32'h0, E_REJ,  32'h100, 8));
    tbl.push_back(mk("s4_rej33",    0,0,32'h0,0,    0,32'h0,0,0,32'h0, E_REJ,  32'h100, 8));
    tbl.push_back(mk("s4_idle",     0,0,32'h0,0,    0,32'h0,0,0,32'h0, E_IDLE, 32'h100, 8));
    run_tbl();

    // Single-beat write followed back-to-back by a len=2 read.
    tbl.push_back(mk("s5_wcmd",     1,1,32'h10,1, 0,32'h0,0,0,32'h0,    E_IDLE,  32'h100, 8));
    tbl.push_back(mk("s5_wbeat",    0,0,32'h0,0,  1,32'h5A5A,0,0,32'h0, E_WBEAT, 32'h10, 1));
    tbl.push_back(mk("s5_b2b_cmd",  1,0,32'h20,2, 0,32'h0,0,0,32'h0,    E_DONE,  32'h10, 1));
    tbl.push_back(mk("s5_rd",       0,0,32'h0,0,  0,32'h0,0,0,32'h0,    E_RD,    32'h20, 2));
    tbl.push_back(mk("s5_rv0",      0,0,32'h0,0,  0,32'h0,0,1,32'hA,    E_RV,    32'h20, 2));
    tbl.push_back(mk("s5_rv1",      0,0,32'h0,0,  0,32'h0,0,1,32'hB,    E_RV,    32'h20, 2));
    tbl.push_back(mk("s5_done",     0,0,32'h0,0,  0,32'h0,0,0,32'h0,    E_DONE,  32'h20, 2));
    run_tbl();

    // Maximum legal burst (32) is accepted and runs to completion.
    tbl.push_back(mk("s6_cmd",      1,0,32'h0,32, 0,32'h0,0,0,32'h0, E_IDLE, 32'h20, 2));
    tbl.push_back(mk("s6_rd",       0,0,32'h0,0,  0,32'h0,0,0,32'h0, E_RD,   32'h0, 32));
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk("s6_beat", 0,0,32'h0,0, 0,32'h0,0,1,32'h100 + 32'(i), E_RV, 32'h0, 32));
    tbl.push_back(mk("s6_done",     0,0,32'h0,0,  0,32'h0,0,0,32'h0, E_DONE, 32'h0, 32));
    run_tbl();

    // Asynchronous reset during beat 2 of a len=5 write.
    tbl.push_back(mk("s7_cmd",      1,1,32'h300,5, 0,32'h0,0,0,32'h0,    E_IDLE,  32'h0, 32));
    tbl.push_back(mk("s7_beat1",    0,0,32'h0,0,   1,32'h1111,0,0,32'h0, E_WBEAT, 32'h300, 5));
    run_tbl();
    wr_valid = 1'b1;
    wr_data  = 32'h2222;
    #2;
    reset   = 1'b1;
    wr_data = '0;
    #1;
    check("s7_rst_async", actual(), '0);
    @(posedge clk);
    #1;
    check("s7_rst_held", actual(), '0);
    zero_inputs();
    reset = 1'b0;
    tbl.push_back(mk("s7_post_rst", 0,0,32'h0,0,  0,32'h0,0,0,32'h0,  E_BUSY, 32'h0, 0));
    tbl.push_back(mk("s7_rcmd",     1,0,32'h44,2, 0,32'h0,0,0,32'h0,  E_IDLE, 32'h0, 0));
    tbl.push_back(mk("s7_rd",       0,0,32'h0,0,  0,32'h0,0,0,32'h0,  E_RD,   32'h44, 2));
    tbl.push_back(mk("s7_rv0",      0,0,32'h0,0,  0,32'h0,0,1,32'h11, E_RV,   32'h44, 2));
    tbl.push_back(mk("s7_rv1",      0,0,32'h0,0,  0,32'h0,0,1,32'h22, E_RV,   32'h44, 2));
    tbl.push_back(mk("s7_done",     0,0,32'h0,0,  0,32'h0,0,0,32'h0,  E_DONE, 32'h44, 2));
    run_tbl();

`ifdef AVM_READ_TIMEOUT_EN
    // Read len=2, slave returns one beat; abort pulse 16 cycles after that beat.
    tbl.push_back(mk("s8_cmd",      1,0,32'h48,2, 0,32'h0,0,0,32'h0,  E_IDLE, 32'h44, 2));
    tbl.push_back(mk("s8_rd",       0,0,32'h0,0,  0,32'h0,0,0,32'h0,  E_RD,   32'h48, 2));
    tbl.push_back(mk("s8_rv0",      0,0,32'h0,0,  0,32'h0,0,1,32'h33, E_RV,   32'h48, 2));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk("s8_wait", 0,0,32'h0,0, 0,32'h0,0,0,32'h0, E_BUSY, 32'h48, 2));
    tbl.push_back(mk("s8_abort",    0,0,32'h0,0,  0,32'h0,0,1,32'h44, E_REJ,  32'h48, 2));
    tbl.push_back(mk("s8_late",     0,0,32'h0,0,  0,32'h0,0,1,32'h55, E_IDLE, 32'h48, 2));
    run_tbl();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
